// File: rtl/data_mem_responder_pkg.sv
// mem_resp_pkg: shared definitions for the data-memory responder.
//   state_t          - responder FSM states (IDLE, BUSY, DONE)
//   LATENCY_DEFAULT  - default number of stall cycles per access
//   CNT_W            - width of the BUSY down-counter
//   WORD_ALIGN_BITS  - byte-offset bits below the word index
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned LATENCY_DEFAULT = 2;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned WORD_ALIGN_BITS = 2;

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: CPU <-> data-memory bus.
//   addr_i, write_data_i, mem_read_i, mem_write_i : requests from the CPU
//   read_data_o, stall_o, err_o                   : responses from the memory
// master = CPU side, slave = memory responder side.
interface data_mem_responder_if #(
    parameter int unsigned DATA_W = 32
);
    logic [31:0]       addr_i;
    logic [DATA_W-1:0] write_data_i;
    logic              mem_read_i;
    logic              mem_write_i;
    logic [DATA_W-1:0] read_data_o;
    logic              stall_o;
    logic              err_o;

    modport master (
        output addr_i, write_data_i, mem_read_i, mem_write_i,
        input  read_data_o, stall_o, err_o
    );

    modport slave (
        input  addr_i, write_data_i, mem_read_i, mem_write_i,
        output read_data_o, stall_o, err_o
    );
endinterface

// File: rtl/data_mem_responder_sram_1rw.sv
// sram_1rw: single-port DEPTH x DATA_W storage, synchronous write and
// synchronous (registered) read. Contents and read register are not reset.
//   i_clk   - clock
//   i_we    - write enable (write wins the port)
//   i_re    - read enable; o_rdata updates only when set
//   i_addr  - word address
//   i_wdata - write data
//   o_rdata - registered read data
module sram_1rw #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory for a CPU datapath.
// Each aligned access stalls the CPU for LATENCY cycles, then presents a
// one-cycle DONE with stall_o low. Misaligned or conflicting requests set a
// sticky error flag.
//   clk_i     - CPU clock
//   reset_b_i - asynchronous active-low reset
//   bus       - slave side of data_mem_responder_if (request/response signals)
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 reset_b_i,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [AW-1:0]      r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_we;
    logic               r_err;
    logic               r_rd_valid;

    logic               w_req;
    logic               w_aligned;
    logic               w_stall;
    logic               w_latch;
    logic               w_err_set;
    logic               w_done_entry;
    logic [AW-1:0]      w_idx_in;
    logic [AW-1:0]      w_idx;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_op_we;
    logic [DATA_W-1:0]  w_sram_q;
    logic               w_unused;

    assign w_req     = bus.mem_read_i | bus.mem_write_i;
    assign w_aligned = (bus.addr_i[WORD_ALIGN_BITS-1:0] == '0);
    assign w_idx_in  = bus.addr_i[AW+WORD_ALIGN_BITS-1:WORD_ALIGN_BITS];
    // Upper address bits alias away by design.
    assign w_unused  = ^bus.addr_i[31:AW+WORD_ALIGN_BITS];

    // With LATENCY==1 DONE is entered straight from IDLE, before anything is
    // latched, so the storage port takes the live request while in IDLE.
    assign w_idx   = (r_state == ST_IDLE) ? w_idx_in         : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? bus.write_data_i : r_wdata;
    assign w_op_we = (r_state == ST_IDLE) ? bus.mem_write_i  : r_we;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stall      = 1'b0;
        w_latch      = 1'b0;
        w_err_set    = 1'b0;
        w_done_entry = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (!w_aligned) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_stall   = 1'b1;
                        w_latch   = 1'b1;
                        w_err_set = bus.mem_read_i & bus.mem_write_i;
                        if (LATENCY == 1) begin
                            w_state_nxt  = ST_DONE;
                            w_done_entry = 1'b1;
                        end else begin
                            w_state_nxt = ST_BUSY;
                            w_cnt_nxt   = CNT_W'(LATENCY - 1);
                        end
                    end
                end
            end
            ST_BUSY: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt  = ST_DONE;
                    w_done_entry = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_b_i) begin
        if (!reset_b_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_latch) begin
                r_addr  <= w_idx_in;
                r_wdata <= bus.write_data_i;
                r_we    <= bus.mem_write_i;
            end
            if (w_done_entry) begin
                r_rd_valid <= ~w_op_we;
            end
        end
    end

    // The storage read register only updates on a load completion, so it
    // doubles as the load result; a store completion masks it to zero.
    sram_1rw #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_sram (
        .i_clk   (clk_i),
        .i_we    (w_done_entry & w_op_we & reset_b_i),
        .i_re    (w_done_entry & ~w_op_we & reset_b_i),
        .i_addr  (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_sram_q)
    );

    assign bus.read_data_o = r_rd_valid ? w_sram_q : '0;
    assign bus.stall_o     = w_stall;
    assign bus.err_o       = r_err;
endmodule
